// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: screen-select flags, lives/level tracking, continue and final countdowns.
// Optional pause support is built in when GAME_PAUSE_EN is defined.
module game_state_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int NUM_LEVELS      = 4,
  parameter int CONTINUE_FRAMES = 600,
  parameter int FINAL_FRAMES    = 300,
  localparam int CMAX = (CONTINUE_FRAMES > FINAL_FRAMES) ? CONTINUE_FRAMES : FINAL_FRAMES,
  localparam int CW   = $clog2(CMAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_btn_i,
  input  logic          pause_btn_i,
  input  logic          frame_tick_i,
  input  logic          player_hit_i,
  input  logic          level_clear_i,
  output logic          is_menu_o,
  output logic          is_playing_o,
  output logic          is_continue_o,
  output logic          is_final_o,
  output logic          paused_o,
  output logic          game_reset_o,
  output logic          win_o,
  output logic [2:0]    lives_o,
  output logic [3:0]    level_o,
  output logic [CW-1:0] countdown_o
);

  typedef enum logic [2:0] {
    S_MENU     = 3'd0,
    S_PLAYING  = 3'd1,
    S_CONTINUE = 3'd2,
    S_FINAL    = 3'd3
`ifdef GAME_PAUSE_EN
    , S_PAUSED = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    lives_d;
  logic [3:0]    level_d;
  logic [CW-1:0] cnt_d;
  logic          win_d, grst_d;
  logic          start_prev;
  logic          start_rise;

  assign start_rise = start_btn_i & ~start_prev;

`ifdef GAME_PAUSE_EN
  logic pause_prev;
  logic pause_rise;
  assign pause_rise = pause_btn_i & ~pause_prev;
  always_ff @(posedge clk_i) begin
    if (rst_i) pause_prev <= 1'b1;
    else       pause_prev <= pause_btn_i;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn_i;
`endif

  always_comb begin
    state_d = state_q;
    lives_d = lives_o;
    level_d = level_o;
    cnt_d   = countdown_o;
    win_d   = win_o;
    grst_d  = 1'b0;
    case (state_q)
      S_MENU: begin
        if (start_rise) begin
          state_d = S_PLAYING;
          lives_d = 3'(LIVES_INIT);
          level_d = '0;
          cnt_d   = '0;
          win_d   = 1'b0;
          grst_d  = 1'b1;
        end
      end
      S_PLAYING: begin
        // A level clear swallows a same-cycle hit; any event swallows a pause press.
        if (level_clear_i) begin
          if (level_o == 4'(NUM_LEVELS - 1)) begin
            state_d = S_FINAL;
            win_d   = 1'b1;
            cnt_d   = CW'(FINAL_FRAMES);
          end else begin
            level_d = level_o + 4'd1;
          end
        end else if (player_hit_i) begin
          if (lives_o <= 3'd1) begin
            state_d = S_CONTINUE;
            lives_d = '0;
            cnt_d   = CW'(CONTINUE_FRAMES);
          end else begin
            lives_d = lives_o - 3'd1;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (pause_rise) begin
          state_d = S_PAUSED;
        end
`endif
      end
`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (pause_rise) state_d = S_PLAYING;
      end
`endif
      S_CONTINUE: begin
        if (start_rise) begin
          state_d = S_PLAYING;
          lives_d = 3'(LIVES_INIT);
          cnt_d   = '0;
          grst_d  = 1'b1;
        end else if (frame_tick_i) begin
          if (countdown_o <= CW'(1)) begin
            state_d = S_FINAL;
            win_d   = 1'b0;
            cnt_d   = CW'(FINAL_FRAMES);
          end else begin
            cnt_d = countdown_o - CW'(1);
          end
        end
      end
      S_FINAL: begin
        if (start_rise || (frame_tick_i && countdown_o <= CW'(1))) begin
          state_d = S_MENU;
          lives_d = '0;
          level_d = '0;
          cnt_d   = '0;
          win_d   = 1'b0;
        end else if (frame_tick_i) begin
          cnt_d = countdown_o - CW'(1);
        end
      end
      default: begin
        state_d = S_MENU;
        lives_d = '0;
        level_d = '0;
        cnt_d   = '0;
        win_d   = 1'b0;
      end
    endcase
  end

  // Flags are decoded from the next state so they stay one-hot and land with the counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_MENU;
      start_prev    <= 1'b1;
      is_menu_o     <= 1'b1;
      is_playing_o  <= 1'b0;
      is_continue_o <= 1'b0;
      is_final_o    <= 1'b0;
      paused_o      <= 1'b0;
      game_reset_o  <= 1'b0;
      win_o         <= 1'b0;
      lives_o       <= '0;
      level_o       <= '0;
      countdown_o   <= '0;
    end else begin
      state_q       <= state_d;
      start_prev    <= start_btn_i;
      is_menu_o     <= (state_d == S_MENU);
      is_continue_o <= (state_d == S_CONTINUE);
      is_final_o    <= (state_d == S_FINAL);
`ifdef GAME_PAUSE_EN
      is_playing_o  <= (state_d == S_PLAYING) || (state_d == S_PAUSED);
      paused_o      <= (state_d == S_PAUSED);
`else
      is_playing_o  <= (state_d == S_PLAYING);
      paused_o      <= 1'b0;
`endif
      game_reset_o  <= grst_d;
      win_o         <= win_d;
      lives_o       <= lives_d;
      level_o       <= level_d;
      countdown_o   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl (default build, pause disabled).
module tb_game_state_ctrl;
  logic clk = 1'b0;
  logic rst, start, pause, tick, hit, clr;
  logic is_menu, is_playing, is_continue, is_final, paused, grst, win;
  logic [2:0] lives;
  logic [3:0] level;
  logic [9:0] cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_btn_i(start), .pause_btn_i(pause),
    .frame_tick_i(tick), .player_hit_i(hit), .level_clear_i(clr),
    .is_menu_o(is_menu), .is_playing_o(is_playing), .is_continue_o(is_continue),
    .is_final_o(is_final), .paused_o(paused), .game_reset_o(grst), .win_o(win),
    .lives_o(lives), .level_o(level), .countdown_o(cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic hit_pulse();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; pause = 1'b0; tick = 1'b0; hit = 1'b0; clr = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_menu", is_menu, 1);
    chk("rst_play", is_playing, 0);
    chk("rst_lives", lives, 0);
    chk("rst_cnt", cnt, 0);
    step();
    chk("held_start_menu", is_menu, 1);

    start = 1'b0; step();
    press_start();
    chk("start_play", is_playing, 1);
    chk("start_lives", lives, 3);
    chk("start_level", level, 0);
    chk("start_grst", grst, 1);
    start = 1'b0; step();
    chk("grst_one_cycle", grst, 0);

    pause = 1'b1; step(); pause = 1'b0;
    chk("no_pause", paused, 0);
    chk("no_pause_play", is_playing, 1);

    for (int i = 1; i <= 3; i++) begin
      clr = 1'b1; step(); clr = 1'b0;
      chk("level_inc", level, i);
    end
    clr = 1'b1; step(); clr = 1'b0;
    chk("win_final", is_final, 1);
    chk("win_flag", win, 1);
    chk("win_cnt", cnt, 300);
    ticks(299);
    chk("final_hold", is_final, 1);
    chk("final_cnt1", cnt, 1);
    ticks(1);
    chk("final_menu", is_menu, 1);
    chk("final_clr_level", level, 0);
    chk("final_clr_cnt", cnt, 0);

    press_start(); start = 1'b0;
    chk("restart_play", is_playing, 1);
    hit_pulse(); chk("hit_lives2", lives, 2);
    hit_pulse(); chk("hit_lives1", lives, 1);
    hit = 1'b1; clr = 1'b1; step(); hit = 1'b0; clr = 1'b0;
    chk("simul_level", level, 1);
    chk("simul_lives", lives, 1);
    chk("simul_play", is_playing, 1);
    hit_pulse();
    chk("cont_state", is_continue, 1);
    chk("cont_lives", lives, 0);
    chk("cont_cnt", cnt, 600);
    ticks(5);
    chk("cont_cnt595", cnt, 595);
    press_start(); start = 1'b0;
    chk("cont_play", is_playing, 1);
    chk("cont_relives", lives, 3);
    chk("cont_level_kept", level, 1);
    chk("cont_grst", grst, 1);
    step();
    chk("cont_grst_off", grst, 0);

    repeat (3) hit_pulse();
    chk("cont2_state", is_continue, 1);
    ticks(600);
    chk("timeout_final", is_final, 1);
    chk("timeout_win", win, 0);
    chk("timeout_cnt", cnt, 300);
    press_start(); start = 1'b0;
    chk("final_start_menu", is_menu, 1);

    step();
    press_start(); start = 1'b0;
    repeat (3) hit_pulse();
    ticks(599);
    chk("cont3_cnt1", cnt, 1);
    tick = 1'b1; start = 1'b1; step(); tick = 1'b0; start = 1'b0;
    chk("start_beats_tick", is_playing, 1);
    chk("start_beats_tick_grst", grst, 1);

    rst = 1'b1; step(); rst = 1'b0;
    chk("midgame_rst", is_menu, 1);
    chk("midgame_rst_lives", lives, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
